// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-fetch stage controller.
package rf_ctrl_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_e;

   localparam logic [1:0] FWD_RF = 2'd0;
   localparam logic [1:0] FWD_EX = 2'd1;
   localparam logic [1:0] FWD_WB = 2'd2;

   // Operand source priority: the youngest producer (EX) wins over WB, then RF.
   function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic wb_hit);
      if (ex_hit)      return FWD_EX;
      else if (wb_hit) return FWD_WB;
      else             return FWD_RF;
   endfunction

endpackage

// File: rtl/rf_stage_control_if.sv
// IR2 / EX / WB inputs and IR3-side outputs of the register-fetch controller.
interface rf_stage_control_if #(
   parameter int OPW  = 4,
   parameter int RAW  = 2,
   parameter int CNTW = 8
);
   logic            ir2_valid;
   logic [OPW-1:0]  ir2_op;
   logic [RAW-1:0]  ir2_rx;
   logic [RAW-1:0]  ir2_ry;
   logic            ex_wr_en;
   logic [RAW-1:0]  ex_wr_addr;
   logic            ex_is_load;
   logic            wb_wr_en;
   logic [RAW-1:0]  wb_wr_addr;
   logic            flush;
   logic            stall;
   logic            ir3_load;
   logic            ir3_valid;
   logic [OPW-1:0]  ir3_op;
   logic            r1r2_load;
   logic            addr1_sel;
   logic [1:0]      fwd1_sel;
   logic [1:0]      fwd2_sel;
   logic [CNTW-1:0] stall_count;

   // Pipeline side: presents IR2 and writer info, consumes the stage controls.
   modport master (
      output ir2_valid, ir2_op, ir2_rx, ir2_ry, ex_wr_en, ex_wr_addr, ex_is_load,
             wb_wr_en, wb_wr_addr, flush,
      input  stall, ir3_load, ir3_valid, ir3_op, r1r2_load, addr1_sel,
             fwd1_sel, fwd2_sel, stall_count
   );

   // Controller side.
   modport slave (
      input  ir2_valid, ir2_op, ir2_rx, ir2_ry, ex_wr_en, ex_wr_addr, ex_is_load,
             wb_wr_en, wb_wr_addr, flush,
      output stall, ir3_load, ir3_valid, ir3_op, r1r2_load, addr1_sel,
             fwd1_sel, fwd2_sel, stall_count
   );
endinterface

// File: rtl/rf_hazard_detect.sv
// Combinational RAW hazard check and forward-select generation for IR2 sources.
module rf_hazard_detect
   import rf_ctrl_pkg::*;
#(
   parameter int RAW    = 2,
   parameter int FWD_EN = 1
) (
   input  logic           src_used,   // IR2 is valid and actually reads its sources
   input  logic [RAW-1:0] src1,
   input  logic [RAW-1:0] src2,
   input  logic           ex_wr_en,
   input  logic [RAW-1:0] ex_wr_addr,
   input  logic           ex_is_load,
   input  logic           wb_wr_en,
   input  logic [RAW-1:0] wb_wr_addr,
   output logic           stall_req,
   output logic [1:0]     fwd1_sel_next,
   output logic [1:0]     fwd2_sel_next
);

   logic ex_hit1, ex_hit2, wb_hit1, wb_hit2;

   // Match each source against the EX and WB destinations and pick stall / forwarding.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      stall_req     = 1'b0;
      fwd1_sel_next = FWD_RF;
      fwd2_sel_next = FWD_RF;

      ex_hit1 = src_used && ex_wr_en && (ex_wr_addr == src1);
      ex_hit2 = src_used && ex_wr_en && (ex_wr_addr == src2);
      wb_hit1 = src_used && wb_wr_en && (wb_wr_addr == src1);
      wb_hit2 = src_used && wb_wr_en && (wb_wr_addr == src2);

      if (FWD_EN != 0) begin
         // Only a load's data is late; everything else can be bypassed.
         stall_req     = ex_is_load && (ex_hit1 || ex_hit2);
         fwd1_sel_next = fwd_pick(ex_hit1, wb_hit1);
         fwd2_sel_next = fwd_pick(ex_hit2, wb_hit2);
      end else begin
         stall_req = ex_hit1 || ex_hit2 || wb_hit1 || wb_hit2;
      end
   end

endmodule

// File: rtl/rf_stage_control.sv
// Register-fetch stage controller: decides whether IR2 advances into IR3,
// drives operand selects, inserts bubbles, handles flush and STOP/halt.
module rf_stage_control
   import rf_ctrl_pkg::*;
#(
   parameter int             OPW      = 4,
   parameter int             RAW      = 2,
   parameter logic [OPW-1:0] ORI_OP   = 4'b0111,
   parameter logic [OPW-1:0] LOAD_OP  = 4'b0000,
   parameter logic [OPW-1:0] STOP_OP  = 4'b0001,
   parameter logic [OPW-1:0] NOP_OP   = 4'b1010,
   parameter logic [RAW-1:0] IMPL_REG = 1,
   parameter int             FWD_EN   = 1,
   parameter int             CNTW     = 8
) (
   input logic               clock,
   input logic               reset,
   rf_stage_control_if.slave bus
);

   // Load-ness arrives on ex_is_load; LOAD_OP only has to stay distinct from the
   // opcodes this block decodes.
   if (LOAD_OP == STOP_OP || LOAD_OP == NOP_OP || ORI_OP == NOP_OP ||
       ORI_OP == STOP_OP || STOP_OP == NOP_OP) begin : g_bad_opcodes
      $error("rf_stage_control: decoded opcodes must be distinct");
   end

   state_e          state_q, state_d;
   logic            ir3_load_q, ir3_load_d;
   logic            ir3_valid_q, ir3_valid_d;
   logic [OPW-1:0]  ir3_op_q, ir3_op_d;
   logic            r1r2_load_q, r1r2_load_d;
   logic            addr1_sel_q, addr1_sel_d;
   logic [1:0]      fwd1_sel_q, fwd1_sel_d;
   logic [1:0]      fwd2_sel_q, fwd2_sel_d;
   logic [CNTW-1:0] stall_count_q, stall_count_d;

   logic            is_ori, src_used, stall_req, stall_c;
   logic [RAW-1:0]  src1;
   logic [1:0]      fwd1_next, fwd2_next;

   // Decode the IR2 source operands.
   always_comb begin
      is_ori   = (bus.ir2_op == ORI_OP);
      src1     = is_ori ? IMPL_REG : bus.ir2_rx;
      src_used = bus.ir2_valid && (bus.ir2_op != NOP_OP) && (bus.ir2_op != STOP_OP);
   end

   rf_hazard_detect #(
      .RAW    (RAW),
      .FWD_EN (FWD_EN)
   ) u_hazard (
      .src_used      (src_used),
      .src1          (src1),
      .src2          (bus.ir2_ry),
      .ex_wr_en      (bus.ex_wr_en),
      .ex_wr_addr    (bus.ex_wr_addr),
      .ex_is_load    (bus.ex_is_load),
      .wb_wr_en      (bus.wb_wr_en),
      .wb_wr_addr    (bus.wb_wr_addr),
      .stall_req     (stall_req),
      .fwd1_sel_next (fwd1_next),
      .fwd2_sel_next (fwd2_next)
   );

   // Next-state and next-output logic; the default is a bubble into IR3.
   always_comb begin
      state_d     = state_q;
      stall_c     = 1'b0;
      ir3_load_d  = 1'b1;
      ir3_valid_d = 1'b0;
      ir3_op_d    = NOP_OP;
      r1r2_load_d = 1'b0;
      addr1_sel_d = addr1_sel_q;
      fwd1_sel_d  = fwd1_sel_q;
      fwd2_sel_d  = fwd2_sel_q;

      case (state_q)
         RUN: begin
            if (bus.flush) begin
               // Squash IR2; this wins over both a hazard and a STOP.
            end else if (stall_req) begin
               stall_c = 1'b1;
            end else begin
               ir3_valid_d = bus.ir2_valid;
               ir3_op_d    = bus.ir2_op;
               r1r2_load_d = 1'b1;
               addr1_sel_d = is_ori;
               fwd1_sel_d  = fwd1_next;
               fwd2_sel_d  = fwd2_next;
               if (bus.ir2_valid && bus.ir2_op == STOP_OP) state_d = HALT;
            end
         end
         HALT: stall_c = 1'b1;
         default: state_d = RUN;
      endcase

      stall_count_d = stall_count_q;
      if (stall_c && stall_count_q != {CNTW{1'b1}}) stall_count_d = stall_count_q + 1'b1;
   end

   // State and IR3-side output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= RUN;
         ir3_load_q    <= 1'b0;
         ir3_valid_q   <= 1'b0;
         ir3_op_q      <= NOP_OP;
         r1r2_load_q   <= 1'b0;
         addr1_sel_q   <= 1'b0;
         fwd1_sel_q    <= FWD_RF;
         fwd2_sel_q    <= FWD_RF;
         stall_count_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q       <= state_d;
         ir3_load_q    <= ir3_load_d;
         ir3_valid_q   <= ir3_valid_d;
         ir3_op_q      <= ir3_op_d;
         r1r2_load_q   <= r1r2_load_d;
         addr1_sel_q   <= addr1_sel_d;
         fwd1_sel_q    <= fwd1_sel_d;
         fwd2_sel_q    <= fwd2_sel_d;
         stall_count_q <= stall_count_d;
      end
   end

   // stall is held low during reset so the front end is never frozen by stale inputs.
   assign bus.stall       = stall_c && reset;
   assign bus.ir3_load    = ir3_load_q;
   assign bus.ir3_valid   = ir3_valid_q;
   assign bus.ir3_op      = ir3_op_q;
   assign bus.r1r2_load   = r1r2_load_q;
   assign bus.addr1_sel   = addr1_sel_q;
   assign bus.fwd1_sel    = fwd1_sel_q;
   assign bus.fwd2_sel    = fwd2_sel_q;
   assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_rf_stage_control.sv
// Directed bench for rf_stage_control: a vector table plus hand-written
// sequences for reset-in-stall, FWD_EN=0 stalls, flush+STOP and HALT saturation.
module tb_rf_stage_control;

   localparam logic [3:0] ORI = 4'b0111;
   localparam logic [3:0] STP = 4'b0001;
   localparam logic [3:0] NOP = 4'b1010;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clock = ~clock;

   rf_stage_control_if #(.OPW(4), .RAW(2), .CNTW(8)) bus1 ();
   rf_stage_control_if #(.OPW(4), .RAW(2), .CNTW(8)) bus0 ();

   rf_stage_control #(.FWD_EN(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
   rf_stage_control #(.FWD_EN(0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));

   // The FWD_EN=0 instance sees exactly the same stimulus.
   assign bus0.ir2_valid  = bus1.ir2_valid;
   assign bus0.ir2_op     = bus1.ir2_op;
   assign bus0.ir2_rx     = bus1.ir2_rx;
   assign bus0.ir2_ry     = bus1.ir2_ry;
   assign bus0.ex_wr_en   = bus1.ex_wr_en;
   assign bus0.ex_wr_addr = bus1.ex_wr_addr;
   assign bus0.ex_is_load = bus1.ex_is_load;
   assign bus0.wb_wr_en   = bus1.wb_wr_en;
   assign bus0.wb_wr_addr = bus1.wb_wr_addr;
   assign bus0.flush      = bus1.flush;

   typedef struct {
      logic       v;   logic [3:0] op;  logic [1:0] rx;  logic [1:0] ry;
      logic       exw; logic [1:0] exa; logic       exl;
      logic       wbw; logic [1:0] wba; logic       fl;
      logic       e_stall; logic e_stall0;
      logic       e_iv; logic [3:0] e_op; logic e_r1r2;
      logic       chk_sel; logic e_a1; logic [1:0] e_f1; logic [1:0] e_f2;
      logic [7:0] e_cnt;
   } vec_t;

   vec_t tv[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [1:0] rx,
                        input logic [1:0] ry, input logic exw, input logic [1:0] exa,
                        input logic exl, input logic wbw, input logic [1:0] wba,
                        input logic fl);
      bus1.ir2_valid = v;   bus1.ir2_op = op;      bus1.ir2_rx = rx;  bus1.ir2_ry = ry;
      bus1.ex_wr_en = exw;  bus1.ex_wr_addr = exa; bus1.ex_is_load = exl;
      bus1.wb_wr_en = wbw;  bus1.wb_wr_addr = wba; bus1.flush = fl;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_stall"},     32'(bus1.stall),       0);
      check({tag, "_ir3_load"},  32'(bus1.ir3_load),    0);
      check({tag, "_r1r2_load"}, 32'(bus1.r1r2_load),   0);
      check({tag, "_ir3_valid"}, 32'(bus1.ir3_valid),   0);
      check({tag, "_ir3_op"},    32'(bus1.ir3_op),      32'(NOP));
      check({tag, "_addr1_sel"}, 32'(bus1.addr1_sel),   0);
      check({tag, "_fwd1_sel"},  32'(bus1.fwd1_sel),    0);
      check({tag, "_fwd2_sel"},  32'(bus1.fwd2_sel),    0);
      check({tag, "_count"},     32'(bus1.stall_count), 0);
   endtask

   task automatic edge_sample();
      @(posedge clock);
      #1;
   endtask

   initial begin
      //       v  op       rx ry exw exa exl wbw wba fl | st st0 iv op     r1 cs a1 f1 f2 cnt
      tv[0] = '{1, 4'b0100, 2, 3, 0, 0, 0, 0, 0, 0,  0, 0, 1, 4'b0100, 1, 1, 0, 0, 0, 0};
      tv[1] = '{1, ORI,     3, 0, 1, 1, 0, 0, 0, 0,  0, 1, 1, ORI,     1, 1, 1, 1, 0, 0};
      tv[2] = '{1, 4'b0100, 2, 0, 1, 2, 1, 0, 0, 0,  1, 1, 0, NOP,     0, 0, 0, 0, 0, 1};
      tv[3] = '{1, 4'b0100, 0, 3, 0, 0, 0, 1, 3, 0,  0, 1, 1, 4'b0100, 1, 1, 0, 0, 2, 1};
      tv[4] = '{1, 4'b0100, 2, 1, 1, 2, 0, 1, 2, 0,  0, 1, 1, 4'b0100, 1, 1, 0, 1, 0, 1};
      tv[5] = '{1, 4'b0100, 1, 1, 1, 1, 0, 1, 1, 0,  0, 1, 1, 4'b0100, 1, 1, 0, 1, 1, 1};
      tv[6] = '{0, 4'b0100, 2, 3, 1, 2, 1, 0, 0, 0,  0, 0, 0, 4'b0100, 1, 0, 0, 0, 0, 1};
      tv[7] = '{1, 4'b0100, 2, 3, 0, 0, 0, 0, 0, 1,  0, 0, 0, NOP,     0, 0, 0, 0, 0, 1};
      tv[8] = '{1, 4'b0100, 3, 2, 1, 2, 1, 0, 0, 0,  1, 1, 0, NOP,     0, 0, 0, 0, 0, 2};
      tv[9] = '{1, 4'b0101, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 4'b0101, 1, 1, 0, 0, 0, 2};

      drive(0, NOP, 0, 0, 0, 0, 0, 0, 0, 0);
      #1 reset = 1'b0;
      #2 check_reset_vals("por");
      @(negedge clock);
      reset = 1'b1;

      // Table: drive IR2, check combinational stall mid-cycle, registered outputs after the edge.
      for (int i = 0; i < 10; i++) begin
         drive(tv[i].v, tv[i].op, tv[i].rx, tv[i].ry, tv[i].exw, tv[i].exa, tv[i].exl,
               tv[i].wbw, tv[i].wba, tv[i].fl);
         @(negedge clock);
         check($sformatf("v%0d_stall", i),  32'(bus1.stall), 32'(tv[i].e_stall));
         check($sformatf("v%0d_stall0", i), 32'(bus0.stall), 32'(tv[i].e_stall0));
         edge_sample();
         check($sformatf("v%0d_ir3_load", i),  32'(bus1.ir3_load),    1);
         check($sformatf("v%0d_ir3_valid", i), 32'(bus1.ir3_valid),   32'(tv[i].e_iv));
         check($sformatf("v%0d_ir3_op", i),    32'(bus1.ir3_op),      32'(tv[i].e_op));
         check($sformatf("v%0d_r1r2", i),      32'(bus1.r1r2_load),   32'(tv[i].e_r1r2));
         check($sformatf("v%0d_count", i),     32'(bus1.stall_count), 32'(tv[i].e_cnt));
         if (tv[i].chk_sel) begin
            check($sformatf("v%0d_addr1", i), 32'(bus1.addr1_sel), 32'(tv[i].e_a1));
            check($sformatf("v%0d_fwd1", i),  32'(bus1.fwd1_sel),  32'(tv[i].e_f1));
            check($sformatf("v%0d_fwd2", i),  32'(bus1.fwd2_sel),  32'(tv[i].e_f2));
         end
      end

      // Reset in the middle of a load-use stall: stall drops, no residual bubble.
      drive(1, 4'b0100, 2, 0, 1, 2, 1, 0, 0, 0);
      @(negedge clock);
      check("mid_stall_pre", 32'(bus1.stall), 1);
      #2 reset = 1'b0;
      #1 check_reset_vals("mid_stall_rst");
      drive(1, 4'b0110, 0, 1, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      reset = 1'b1;
      #1 check("post_rst_stall", 32'(bus1.stall), 0);
      edge_sample();
      check("post_rst_valid", 32'(bus1.ir3_valid), 1);
      check("post_rst_op",    32'(bus1.ir3_op),    32'(4'b0110));
      check("post_rst_r1r2",  32'(bus1.r1r2_load), 1);

      // WB hazard on ry: FWD_EN=0 stalls every cycle, FWD_EN=1 forwards from WB.
      drive(1, 4'b0100, 0, 3, 0, 0, 0, 1, 3, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check($sformatf("wb%0d_stall0", k), 32'(bus0.stall), 1);
         check($sformatf("wb%0d_stall1", k), 32'(bus1.stall), 0);
         edge_sample();
      end
      check("wb_count0", 32'(bus0.stall_count), 3);
      check("wb_count1", 32'(bus1.stall_count), 0);
      check("wb_fwd2",   32'(bus1.fwd2_sel),    2);
      check("wb_valid0", 32'(bus0.ir3_valid),   0);

      // STOP together with flush: bubble, and the controller stays in RUN.
      drive(1, STP, 0, 0, 0, 0, 0, 0, 0, 1);
      edge_sample();
      check("flstop_valid", 32'(bus1.ir3_valid), 0);
      check("flstop_op",    32'(bus1.ir3_op),    32'(NOP));
      drive(1, 4'b0100, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      check("flstop_stall", 32'(bus1.stall), 0);
      edge_sample();
      check("flstop_run", 32'(bus1.ir3_valid), 1);

      // STOP advances, then HALT: stall every cycle, flush ignored, count saturates.
      drive(1, STP, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      check("stop_stall_pre", 32'(bus1.stall), 0);
      edge_sample();
      check("stop_op",    32'(bus1.ir3_op),    32'(STP));
      check("stop_valid", 32'(bus1.ir3_valid), 1);
      drive(1, 4'b0100, 0, 0, 0, 0, 0, 0, 0, 1);
      @(negedge clock);
      check("halt_stall", 32'(bus1.stall), 1);
      edge_sample();
      check("halt_valid", 32'(bus1.ir3_valid),   0);
      check("halt_load",  32'(bus1.ir3_load),    1);
      check("halt_r1r2",  32'(bus1.r1r2_load),   0);
      check("halt_cnt1",  32'(bus1.stall_count), 1);
      repeat (9) edge_sample();
      check("halt_cnt10", 32'(bus1.stall_count), 10);
      repeat (260) edge_sample();
      check("halt_sat", 32'(bus1.stall_count), 255);
      check("halt_stall_late", 32'(bus1.stall), 1);

      // Reset while halted returns to RUN with reset outputs.
      @(negedge clock);
      reset = 1'b0;
      #1 check_reset_vals("halt_rst");
      drive(1, 4'b0011, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      reset = 1'b1;
      #1 check("halt_rst_stall", 32'(bus1.stall), 0);
      edge_sample();
      check("halt_rst_valid", 32'(bus1.ir3_valid), 1);
      check("halt_rst_op",    32'(bus1.ir3_op),    32'(4'b0011));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rf_stage_control.md
# rf_stage_control

Parametrised register-fetch stage controller for the pipelined processor, sitting between the IR2 (decode) and IR3 (execute) pipeline registers. Each cycle it decides whether the IR2 instruction advances into IR3. It drives register-file address select and operand forwarding selects, and detects load-use and no-forward hazards, stalling the front end when needed. It also handles flush and STOP/halt, and counts stall cycles for performance monitoring.

## Interface

Parameters:
- OPW, 4, opcode width
- RAW, 2, register address width
- ORI_OP, 4'b0111, opcode whose first source is the implicit register
- LOAD_OP, 4'b0000, load opcode (informational; load-ness arrives via ex_is_load)
- STOP_OP, 4'b0001, halt opcode
- NOP_OP, 4'b1010, opcode with no source operands
- IMPL_REG, 1, implicit register address used by ORI_OP
- FWD_EN, 1, 1 = forwarding enabled; 0 = stall on every RAW hazard
- CNTW, 8, stall counter width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ir2_valid  in  1  IR2 holds a real instruction
- ir2_op  in  OPW  IR2 opcode
- ir2_rx  in  RAW  IR2 first source register field
- ir2_ry  in  RAW  IR2 second source register field
- ex_wr_en  in  1  instruction in IR3 writes a register
- ex_wr_addr  in  RAW  its destination
- ex_is_load  in  1  instruction in IR3 is a load
- wb_wr_en  in  1  instruction in writeback writes a register
- wb_wr_addr  in  RAW  its destination
- flush  in  1  squash IR2 (taken branch)
- stall  out  1  combinational; holds PC/IR1/IR2
- ir3_load  out  1  load IR3 this edge
- ir3_valid  out  1  IR3 holds a real instruction
- ir3_op  out  OPW  opcode latched into IR3
- r1r2_load  out  1  load R1/R2 operand registers
- addr1_sel  out  1  0 = ir2_rx, 1 = IMPL_REG to RF port 1
- fwd1_sel  out  2  operand 1 source: 0 RF, 1 EX result, 2 WB result
- fwd2_sel  out  2  operand 2 source, same encoding
- stall_count  out  CNTW  saturating count of stalled cycles

## Operation

- src1 = IMPL_REG if ir2_op==ORI_OP, else ir2_rx; src2 = ir2_ry.
- A valid instruction reads src1 and src2 unless its opcode is NOP_OP or STOP_OP.
- ex_hit_n = ex_wr_en && ex_wr_addr==src_n; wb_hit_n = wb_wr_en && wb_wr_addr==src_n.
- Stall condition:
  - FWD_EN=1: ir2_valid && ex_is_load && any ex_hit (load-use).
  - FWD_EN=0: ir2_valid && any ex_hit or wb_hit.
- Forward select per operand: EX over WB over RF. With FWD_EN=0 it is always RF.
- States: RUN, HALT.
  - RUN, flush: ir3_valid<=0, ir3_op<=NOP_OP, r1r2_load<=0, ir3_load<=1. Flush overrides stall and STOP.
  - RUN, stall: bubble into IR3 (ir3_valid<=0, ir3_op<=NOP_OP), r1r2_load<=0, ir3_load<=1.
  - RUN, normal: ir3_valid<=ir2_valid, ir3_op<=ir2_op, r1r2_load<=1, ir3_load<=1; addr1_sel and fwd selects registered from IR2.
  - RUN, valid STOP_OP advancing (no flush): STOP enters IR3, then go to HALT.
  - HALT: stall=1, ir3_load<=1, ir3_valid<=0, r1r2_load<=0; flush ignored; exit only by reset.
- stall_count increments on every cycle with stall=1, including HALT cycles, and saturates at all-ones.

## Timing

- All outputs except stall are registered and update on the rising clock edge from that cycle's inputs; stall is same-cycle combinational.
- Latency: IR2 contents are reflected on the IR3-side outputs one edge later.
- Load-use costs exactly one bubble, since the load leaves EX on the next edge.
- Reset (reset=0) asynchronously clears:
  - ir3_load, r1r2_load, ir3_valid, addr1_sel, fwd1_sel, fwd2_sel and stall_count to 0;
  - ir3_op to NOP_OP;
  - state to RUN.
- stall is 0 while reset is asserted.
- Reset mid-stall or in HALT returns to RUN with no residual bubble.

## Structure

- Package rf_ctrl_pkg holds:
  - the state enum {RUN, HALT};
  - the forward-select constants FWD_RF=0, FWD_EX=1, FWD_WB=2.
- Sub-module rf_hazard_detect is combinational. It takes src fields, EX/WB write info and FWD_EN, and produces stall_req, fwd1_sel_next and fwd2_sel_next.

## Test plan

- Reset, then ir2_valid=1, ir2_op=4'b0100, rx=2, ry=3, no writers -> next edge: ir3_valid=1, ir3_op=4'b0100, r1r2_load=1, addr1_sel=0, fwd1_sel=0, fwd2_sel=0, stall=0.
- ir2_op=ORI_OP, rx=3, ex_wr_en=1, ex_wr_addr=1, ex_is_load=0 -> addr1_sel=1, fwd1_sel=1, stall=0.
- ex_is_load=1, ex_wr_addr=2, IR2 rx=2 -> stall=1 same cycle; next edge ir3_valid=0 and r1r2_load=0; stall_count goes 0->1.
- FWD_EN=0 with wb_wr_en=1, wb_wr_addr=3, ry=3 -> stall=1 while the hazard persists; with FWD_EN=1 -> fwd2_sel=2, no stall.
- ex_wr_addr and wb_wr_addr both equal rx (FWD_EN=1) -> fwd1_sel=1 (EX wins over WB).
- Valid STOP_OP -> ir3_op=STOP_OP, then HALT: stall=1 every cycle and stall_count saturates at 255; asserting flush together with STOP instead gives a bubble and stays in RUN; reset low in HALT returns to RUN with all outputs at their reset values.
